max_pool_2x2: RTL and testbench

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the ReLU activation. It consumes one activation per beat in raster order (row-major, one frame of IMG_H × IMG_W), and emits one pooled value per 2×2 window in raster order of the pooled map. A half-width line buffer holds the horizontal maxima of each even row. Output uses a registered valid/ready interface, and backpressure propagates upstream.

---
 rtl/cnn_pkg.sv | 27 ++
 rtl/pool_line_buffer.sv | 26 ++
 rtl/max_pool_2x2.sv | 136 +++++++++++++
 tb/tb_max_pool_2x2.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming stages: default data width, the
// signed maximum used by the pooling datapath, and pooled-frame geometry checks.
package cnn_pkg;

    localparam int DWIDTH_DEFAULT = 32;

    // Widest activation the shared helpers support; narrower data is sign-extended into it.
    localparam int MAX_DWIDTH = 64;

    typedef logic signed [MAX_DWIDTH-1:0] wide_t;

    // Signed maximum; on a tie either operand is the same value.
    function automatic wide_t smax(input wide_t a, input wide_t b);
        return (a >= b) ? a : b;
    endfunction

    // 2x2 stride-2 pooling needs even, non-degenerate frame dimensions.
    function automatic bit pool_dims_ok(input int img_w, input int img_h);
        return (img_w >= 2) && (img_h >= 2) && ((img_w % 2) == 0) && ((img_h % 2) == 0);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line buffer holding the horizontal maxima of the last even row.
// One synchronous write port, one asynchronous read port, no reset.
module pool_line_buffer #(
    parameter int DEPTH  = 14,
    parameter int DWIDTH = 32,
    parameter int AW     = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic signed [DWIDTH-1:0] rdata
);

    logic signed [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max pooling over raster-order frames with a single
// registered output slot; backpressure stalls the input directly.
module max_pool_2x2
    import cnn_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DWIDTH-1:0] out_data,
    output logic                     out_last
);

    localparam int CW       = idx_width(IMG_W);
    localparam int RW       = idx_width(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int AW       = idx_width(LB_DEPTH);

    generate
        if (!pool_dims_ok(IMG_W, IMG_H)) begin : g_bad_dims
            $error("max_pool_2x2: IMG_W and IMG_H must be even and >= 2");
        end
        if (DWIDTH > MAX_DWIDTH || DWIDTH < 1) begin : g_bad_width
            $error("max_pool_2x2: DWIDTH out of supported range");
        end
    endgenerate

    logic [CW-1:0]            col_reg, col_next;
    logic [RW-1:0]            row_reg, row_next;
    logic signed [DWIDTH-1:0] pair_reg, pair_next;
    logic                     out_valid_reg, out_valid_next;
    logic signed [DWIDTH-1:0] out_data_reg, out_data_next;
    logic                     out_last_reg, out_last_next;

    logic                     accept;
    logic                     col_last;
    logic                     row_last;
    logic                     odd_col;
    logic                     odd_row;
    logic                     lb_we;
    logic                     load;
    logic [AW-1:0]            lb_addr;
    logic signed [DWIDTH-1:0] lb_rdata;
    logic signed [DWIDTH-1:0] hmax;
    logic signed [DWIDTH-1:0] vmax;

    // A new beat may enter whenever the output slot is empty or being drained.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    assign col_last = (col_reg == CW'(IMG_W - 1));
    assign row_last = (row_reg == RW'(IMG_H - 1));
    assign odd_col  = col_reg[0];
    assign odd_row  = row_reg[0];

    assign lb_addr  = AW'(col_reg >> 1);
    assign hmax     = DWIDTH'(smax(wide_t'(pair_reg), wide_t'(in_data)));
    assign vmax     = DWIDTH'(smax(wide_t'(lb_rdata), wide_t'(hmax)));

    // Even rows park their horizontal maxima; odd rows close the window.
    assign lb_we    = accept && odd_col && !odd_row;
    assign load     = accept && odd_col && odd_row;

    pool_line_buffer #(
        .DEPTH  (LB_DEPTH),
        .DWIDTH (DWIDTH),
        .AW     (AW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (hmax),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_comb begin
        col_next       = col_reg;
        row_next       = row_reg;
        pair_next      = pair_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;

        if (accept) begin
            if (col_last) begin
                col_next = '0;
                row_next = row_last ? '0 : row_reg + RW'(1);
            end else begin
                col_next = col_reg + CW'(1);
            end
            if (!odd_col) begin
                pair_next = in_data;
            end
        end

        // A load wins over a drain so a back-to-back result never leaves a bubble.
        if (load) begin
            out_valid_next = 1'b1;
            out_data_next  = vmax;
            out_last_next  = row_last && col_last;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg       <= '0;
            row_reg       <= '0;
            pair_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else begin
            col_reg       <= col_next;
            row_reg       <= row_next;
            pair_reg      <= pair_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2 on a 4x4 frame: a window-level reference
// model checked every cycle, plus literal expectations for the directed frames.
module tb_max_pool_2x2;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic                 out_last;

    always #5 clk = ~clk;

    max_pool_2x2 #(.DWIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: store the frame pixels, emit the max of each completed 2x2 window.
    typedef struct {
        logic signed [DW-1:0] d;
        logic                 l;
    } exp_t;

    logic signed [DW-1:0] pix [H][W];
    int                   m_row = 0;
    int                   m_col = 0;
    exp_t                 expq[$];
    logic signed [DW-1:0] got_d[$];
    logic                 got_l[$];
    int                   stall_cnt = 0;
    int                   in_stall  = 0;

    function automatic logic signed [DW-1:0] max4(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                                  input logic signed [DW-1:0] c, input logic signed [DW-1:0] d);
        logic signed [DW-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_out_valid", out_valid, 0);
            check("reset_out_data", out_data, 0);
            check("reset_out_last", out_last, 0);
            expq.delete();
            m_row = 0;
            m_col = 0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (expq.size() == 0) begin
                check("idle_out_valid", out_valid, 0);
            end else begin
                check("out_valid", out_valid, 1);
                check("out_data", out_data, expq[0].d);
                check("out_last", out_last, expq[0].l);
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (in_valid && !in_ready) in_stall++;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                if (expq.size() > 0) void'(expq.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_t e;
                pix[m_row][m_col] = in_data;
                if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                    e.d = max4(pix[m_row-1][m_col-1], pix[m_row-1][m_col], pix[m_row][m_col-1], pix[m_row][m_col]);
                    e.l = (m_row == H - 1) && (m_col == W - 1);
                    expq.push_back(e);
                end
                if (m_col == W - 1) begin
                    m_col = 0;
                    m_row = (m_row == H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col = m_col + 1;
                end
            end
        end
    end

    // out_ready driver: steady high, random, or a 3-cycle hold triggered by value 5.
    int ready_mode = 0;
    int hold_cnt   = 0;
    bit bp_arm     = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_arm && out_valid && out_data == 5) begin
                hold_cnt = 3;
                bp_arm   = 1'b0;
            end
            if (hold_cnt > 0) begin
                out_ready = 1'b0;
                hold_cnt--;
            end else if (ready_mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic send_beat(input logic signed [DW-1:0] v);
        int tries = 0;
        in_valid = 1'b1;
        in_data  = v;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            tries++;
            if (tries > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", tries);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic signed [DW-1:0] f[W*H], input bit gaps);
        for (int i = 0; i < W * H; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
            send_beat(f[i]);
        end
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 1'b0;
        while ((expq.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_queue_empty", expq.size(), 0);
    endtask

    task automatic expect_log(input string name, input int n,
                              input logic signed [DW-1:0] d[8], input logic l[8]);
        check({name, "_count"}, got_d.size(), n);
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            check($sformatf("%s_data[%0d]", name, i), got_d[i], d[i]);
            check($sformatf("%s_last[%0d]", name, i), got_l[i], l[i]);
        end
        $display("%s: %0d outputs logged", name, got_d.size());
        got_d.delete();
        got_l.delete();
    endtask

    logic signed [DW-1:0] ramp [W*H];
    logic signed [DW-1:0] neg  [W*H];
    logic signed [DW-1:0] rnd  [W*H];
    logic signed [DW-1:0] exp_d [8];
    logic                 exp_l [8];

    initial begin
        for (int i = 0; i < W * H; i++) ramp[i] = DW'(i);
        neg = '{-9, -2, -7, -4, -3, -8, -1, -6, -9, -2, -7, -4, -3, -8, -1, -6};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Ramp frame
        send_frame(ramp, 1'b0);
        drain();
        exp_d = '{5, 7, 13, 15, 0, 0, 0, 0};
        exp_l = '{0, 0, 0, 1, 0, 0, 0, 0};
        expect_log("ramp", 4, exp_d, exp_l);

        // Negative data
        send_frame(neg, 1'b0);
        drain();
        exp_d = '{-2, -1, -2, -1, 0, 0, 0, 0};
        expect_log("signed", 4, exp_d, exp_l);

        // Backpressure on value 5
        stall_cnt = 0;
        bp_arm    = 1'b1;
        send_frame(ramp, 1'b0);
        drain();
        check("bp_stall_cycles", stall_cnt, 3);
        exp_d = '{5, 7, 13, 15, 0, 0, 0, 0};
        expect_log("backpressure", 4, exp_d, exp_l);

        // Back-to-back frames with continuous valid
        in_stall = 0;
        send_frame(ramp, 1'b0);
        send_frame(ramp, 1'b0);
        drain();
        check("b2b_input_stalls", in_stall, 0);
        exp_d = '{5, 7, 13, 15, 5, 7, 13, 15};
        exp_l = '{0, 0, 0, 1, 0, 0, 0, 1};
        expect_log("back_to_back", 8, exp_d, exp_l);

        // Reset mid-frame
        for (int i = 0; i < 6; i++) send_beat(ramp[i]);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        got_d.delete();
        got_l.delete();
        send_frame(ramp, 1'b0);
        drain();
        exp_d = '{5, 7, 13, 15, 0, 0, 0, 0};
        exp_l = '{0, 0, 0, 1, 0, 0, 0, 0};
        expect_log("reset_mid_frame", 4, exp_d, exp_l);

        // Random data, random gaps, random backpressure
        ready_mode = 1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < W * H; i++) rnd[i] = DW'($urandom());
            send_frame(rnd, 1'b1);
        end
        drain();
        ready_mode = 0;
        idle(2);
        check("random_output_count", got_d.size(), 16);
        $display("random: %0d outputs logged", got_d.size());
        got_d.delete();
        got_l.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
